// File: rtl/bram_dp_pkg.sv
// Shared types and constants for the bram_dp_init dual-port RAM wrapper.
// BRAM_DP_OUTREG_EN selects the read latency (2 when defined, 1 otherwise).
package bram_dp_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

`ifdef BRAM_DP_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   // Port whose write survives when both ports write the same address.
   localparam logic WIN_PORT = 1'b0;

endpackage

// File: rtl/bram_dp_core.sv
// Storage-only two-port array: synchronous writes, registered reads, no reset
// and no forwarding. Used by bram_dp_init (BRAM_DP_OUTREG_EN has no effect here).
module bram_dp_core #(
   parameter int ABITS = 13,
   parameter int DBITS = 2
) (
   input  logic             clk_i,
   input  logic             we0_i,
   input  logic             re0_i,
   input  logic [ABITS-1:0] a0_i,
   input  logic [DBITS-1:0] d0_i,
   output logic [DBITS-1:0] q0_o,
   input  logic             we1_i,
   input  logic             re1_i,
   input  logic [ABITS-1:0] a1_i,
   input  logic [DBITS-1:0] d1_i,
   output logic [DBITS-1:0] q1_o
);

   logic [DBITS-1:0] mem_q [2**ABITS];
   logic [DBITS-1:0] q0_q;
   logic [DBITS-1:0] q1_q;

   // Port 0 is written last so it wins if both enables reach the same word.
   always_ff @(posedge clk_i) begin
      if (we1_i) mem_q[a1_i] <= d1_i;
      if (we0_i) mem_q[a0_i] <= d0_i;
      if (re0_i) q0_q <= mem_q[a0_i];
      if (re1_i) q1_q <= mem_q[a1_i];
   end

   assign q0_o = q0_q;
   assign q1_o = q1_q;

endmodule

// File: rtl/bram_dp_init.sv
// Dual-port RAM wrapper with a hardware clear sequencer, collision rules and RDY.
// Define BRAM_DP_OUTREG_EN to add an output register stage (read latency 2).
module bram_dp_init
   import bram_dp_pkg::*;
#(
   parameter int               ABITS    = 13,
   parameter int               DBITS    = 2,
   parameter logic [DBITS-1:0] INIT_VAL = '0
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CLR,
   output logic             RDY,
   input  logic [ABITS-1:0] A0,
   input  logic [DBITS-1:0] D0,
   input  logic             WE0,
   input  logic             CE0,
   output logic [DBITS-1:0] Q0,
   input  logic [ABITS-1:0] A1,
   input  logic [DBITS-1:0] D1,
   input  logic             WE1,
   input  logic             CE1,
   output logic [DBITS-1:0] Q1,
   output state_t           dbg_state_o
);

   localparam logic [ABITS-1:0] LAST_ADDR = '1;

   state_t           state_q;
   logic [ABITS-1:0] cnt_q;
   logic             rdy_q;

   // RDY is the ready half of the port handshake: a port access (CE=1) is
   // accepted on a rising edge only when RDY=1; while RDY=0 it is dropped.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_READY;
                  rdy_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_READY: begin
               if (CLR) begin
                  state_q <= ST_CLEAR;
                  rdy_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               rdy_q   <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign RDY         = rdy_q;
   assign dbg_state_o = state_q;

   logic             clearing;
   logic             same_addr;
   logic             usr_we0;
   logic             usr_we1;
   logic             wr_clash;
   logic             we0_eff;
   logic             we1_eff;
   logic             re0;
   logic             re1;
   logic             fwd0;
   logic             fwd1;
   logic             core_we0;
   logic [ABITS-1:0] core_a0;
   logic [DBITS-1:0] core_d0;
   logic [DBITS-1:0] core_q0;
   logic [DBITS-1:0] core_q1;

   assign clearing  = (state_q == ST_CLEAR);
   assign same_addr = (A0 == A1);
   assign usr_we0   = rdy_q & CE0 & WE0;
   assign usr_we1   = rdy_q & CE1 & WE1;
   assign wr_clash  = usr_we0 & usr_we1 & same_addr;
   assign we0_eff   = usr_we0 & ~(wr_clash & WIN_PORT);
   assign we1_eff   = usr_we1 & ~(wr_clash & ~WIN_PORT);
   assign re0       = rdy_q & CE0 & ~WE0;
   assign re1       = rdy_q & CE1 & ~WE1;
   // A read colliding with the other port's write returns the new data.
   assign fwd0      = re0 & we1_eff & same_addr;
   assign fwd1      = re1 & we0_eff & same_addr;

   // The clear sequencer borrows port 0 of the array while not ready.
   assign core_we0 = clearing | we0_eff;
   assign core_a0  = clearing ? cnt_q : A0;
   assign core_d0  = clearing ? INIT_VAL : D0;

   bram_dp_core #(
      .ABITS (ABITS),
      .DBITS (DBITS)
   ) u_core (
      .clk_i (CLK),
      .we0_i (core_we0),
      .re0_i (re0),
      .a0_i  (core_a0),
      .d0_i  (core_d0),
      .q0_o  (core_q0),
      .we1_i (we1_eff),
      .re1_i (re1),
      .a1_i  (A1),
      .d1_i  (D1),
      .q1_o  (core_q1)
   );

   logic             vld0_q;
   logic             vld1_q;
   logic             fwd0_q;
   logic             fwd1_q;
   logic [DBITS-1:0] fdat0_q;
   logic [DBITS-1:0] fdat1_q;
   logic [DBITS-1:0] rd0_d;
   logic [DBITS-1:0] rd1_d;

   // Source selection only changes on a read, so Q holds between reads.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         vld0_q  <= 1'b0;
         vld1_q  <= 1'b0;
         fwd0_q  <= 1'b0;
         fwd1_q  <= 1'b0;
         fdat0_q <= '0;
         fdat1_q <= '0;
      end else begin
         if (re0) begin
            vld0_q <= 1'b1;
            fwd0_q <= fwd0;
            if (fwd0) fdat0_q <= D1;
         end
         if (re1) begin
            vld1_q <= 1'b1;
            fwd1_q <= fwd1;
            if (fwd1) fdat1_q <= D0;
         end
      end
   end

   assign rd0_d = !vld0_q ? '0 : (fwd0_q ? fdat0_q : core_q0);
   assign rd1_d = !vld1_q ? '0 : (fwd1_q ? fdat1_q : core_q1);

`ifdef BRAM_DP_OUTREG_EN
   logic [DBITS-1:0] q0_q;
   logic [DBITS-1:0] q1_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q0_q <= '0;
         q1_q <= '0;
      end else begin
         q0_q <= rd0_d;
         q1_q <= rd1_d;
      end
   end

   assign Q0 = q0_q;
   assign Q1 = q1_q;
`else
   assign Q0 = rd0_d;
   assign Q1 = rd1_d;
`endif

endmodule

// File: tb/tb_bram_dp_init.sv
// Self-checking bench for bram_dp_init (ABITS=4, DBITS=8, INIT_VAL=8'hA5);
// works with or without BRAM_DP_OUTREG_EN via the package read-latency constant.
module tb_bram_dp_init;
   import bram_dp_pkg::*;

   localparam int         AB    = 4;
   localparam int         DB    = 8;
   localparam int         DEPTH = 16;
   localparam logic [7:0] IV    = 8'hA5;

   logic       CLK;
   logic       RSTN;
   logic       CLR;
   logic       RDY;
   logic [3:0] A0, A1;
   logic [7:0] D0, D1, Q0, Q1;
   logic       WE0, CE0, WE1, CE1;
   state_t     dbg_state;

   bram_dp_init #(
      .ABITS    (AB),
      .DBITS    (DB),
      .INIT_VAL (IV)
   ) dut (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .CLR         (CLR),
      .RDY         (RDY),
      .A0          (A0),
      .D0          (D0),
      .WE0         (WE0),
      .CE0         (CE0),
      .Q0          (Q0),
      .A1          (A1),
      .D1          (D1),
      .WE1         (WE1),
      .CE1         (CE1),
      .Q1          (Q1),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] mem_m [DEPTH];
   int         clear_left;
   logic [7:0] m0, m1;
   logic [7:0] e0, e1;
   logic       e_rdy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      clear_left = DEPTH;
      m0 = '0; m1 = '0;
      e0 = '0; e1 = '0;
      e_rdy = 1'b0;
   endtask

   task automatic drive(input logic ce0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic ce1, input logic we1, input logic [3:0] a1, input logic [7:0] d1,
                        input logic clr);
      CE0 = ce0; WE0 = we0; A0 = a0; D0 = d0;
      CE1 = ce1; WE1 = we1; A1 = a1; D1 = d1;
      CLR = clr;
   endtask

   task automatic idle();
      drive(0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 0);
   endtask

   // Advance one clock: update the model from the current inputs, then compare.
   task automatic step();
      logic [7:0] p0, p1;
      logic       w0, w1, same;
      p0 = m0; p1 = m1;
      if (clear_left > 0) begin
         mem_m[DEPTH - clear_left] = IV;
         clear_left--;
      end else begin
         w0   = CE0 && WE0;
         w1   = CE1 && WE1;
         same = (A0 == A1);
         if (CE0 && !WE0) m0 = (w1 && same) ? D1 : mem_m[A0];
         if (CE1 && !WE1) m1 = (w0 && same) ? D0 : mem_m[A1];
         if (w1 && !(w0 && same)) mem_m[A1] = D1;
         if (w0) mem_m[A0] = D0;
         if (CLR) clear_left = DEPTH;
      end
      e_rdy = (clear_left == 0);
      e0 = (RD_LAT == 1) ? m0 : p0;
      e1 = (RD_LAT == 1) ? m1 : p1;
      @(posedge CLK);
      @(negedge CLK);
      check("rdy", RDY, e_rdy);
      check("q0", Q0, e0);
      check("q1", Q1, e1);
   endtask

   task automatic random_read_inputs();
      drive(1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)));
   endtask

   // Asynchronous reset applied between edges; outputs must clear immediately.
   task automatic apply_reset();
      RSTN = 1'b0;
      #2;
      check("rst_rdy", RDY, 0);
      check("rst_q0", Q0, 0);
      check("rst_q1", Q1, 0);
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      int cyc;
      cyc = 0;
      while (RDY !== 1'b1 && cyc < 40) begin
         random_read_inputs();
         step();
         cyc++;
      end
      idle();
      check(name, cyc, exp_cycles);
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, 0, 4'(a), 8'd0, 1, 0, 4'(DEPTH - 1 - a), 8'd0, 0);
         step();
      end
      idle();
      step();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic       ce0, we0;
      logic [3:0] a0;
      logic [7:0] d0;
      logic       ce1, we1;
      logic [3:0] a1;
      logic [7:0] d1;
      logic [7:0] x0, x1;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{1, 1, 4'd5, 8'h3C, 0, 0, 4'd0, 8'h00, 8'hA5, 8'hA5};
      tbl[1] = '{0, 0, 4'd0, 8'h00, 1, 0, 4'd5, 8'h00, 8'hA5, 8'h3C};
      tbl[2] = '{1, 1, 4'd7, 8'h11, 1, 1, 4'd7, 8'h22, 8'hA5, 8'h3C};
      tbl[3] = '{1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00, 8'h11, 8'h11};
      tbl[4] = '{1, 0, 4'd2, 8'h00, 1, 1, 4'd2, 8'h77, 8'h77, 8'h11};
      tbl[5] = '{0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00, 8'h77, 8'h77};
      tbl[6] = '{1, 1, 4'd9, 8'h5A, 1, 0, 4'd9, 8'h00, 8'h77, 8'h5A};
      tbl[7] = '{1, 0, 4'd0, 8'h00, 1, 0, 4'd0, 8'h00, 8'hA5, 8'hA5};
      tbl[8] = '{1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00, 8'h3C, 8'hA5};

      RSTN = 1'b0;
      idle();
      model_reset();
      repeat (2) @(negedge CLK);

      // Reset, clear timing, every word initialised.
      apply_reset();
      wait_ready("rdy_after_reset", DEPTH);
      read_all();

      // Write, forwarding and collision vectors.
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].ce0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
               tbl[i].ce1, tbl[i].we1, tbl[i].a1, tbl[i].d1, 0);
         step();
         idle();
         if (RD_LAT == 2) step();
         check($sformatf("vec%0d_q0", i), Q0, tbl[i].x0);
         check($sformatf("vec%0d_q1", i), Q1, tbl[i].x1);
      end

      // CLR with a read in the same cycle, reads during the clear.
      drive(1, 1, 4'd1, 8'hC3, 1, 1, 4'd3, 8'h96, 0);
      step();
      drive(1, 0, 4'd1, 8'h00, 1, 0, 4'd3, 8'h00, 1);
      step();
      wait_ready("rdy_after_clr", DEPTH);
      read_all();

      // Reset at clear counter 9, reads ignored during the clear.
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 4'(i), 8'd0, 1, 0, 4'(i), 8'd0, 1);
         step();
      end
      apply_reset();
      wait_ready("rdy_after_midclear_rst", DEPTH);
      check("q0_zero_before_read", Q0, 0);
      check("q1_zero_before_read", Q1, 0);
      read_all();

      // Randomised traffic on a narrow address range to provoke collisions.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
               ($urandom_range(0, 79) == 0));
         step();
      end
      idle();
      repeat (DEPTH + 2) step();
      read_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_dp_init.md
Name: bram_dp_init

Overview:
- Parametrised true dual-port synchronous SRAM wrapper; next generation of the fixed-size BRAM_*x* wrappers.
- Adds:
  - width/depth parameters;
  - a hardware clear sequencer that fills memory with INIT_VAL after reset or on request;
  - deterministic same-address collision rules;
  - a ready flag.
- Sits under accelerator PLM/scratchpad logic; storage lives in a generic two-port array.

Parameters:
- ABITS, 13, address width; DEPTH = 2**ABITS words.
- DBITS, 2, data width per word.
- INIT_VAL, 0, DBITS-wide value written to every word by the clear sequencer.

Ports:
- CLK  in  1  clock; all activity on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- CLR  in  1  pulse; restarts the clear sequence; honoured only while RDY=1.
- RDY  out  1  1 = clear finished, ports accepted.
- A0  in  ABITS  port 0 address.
- D0  in  DBITS  port 0 write data.
- WE0  in  1  port 0 write enable (qualified by CE0).
- CE0  in  1  port 0 chip enable.
- Q0  out  DBITS  port 0 read data.
- A1, D1, WE1, CE1, Q1  as port 0, for port 1.

Behaviour:
- States: CLEAR, READY.
- Reset (RSTN=0, async):
  - state=CLEAR, clear counter=0, RDY=0, Q0=Q1=0.
  - Memory contents are not reset directly; the clear sequence overwrites them.
- CLEAR:
  - Each cycle writes INIT_VAL to address counter, then increments the counter.
  - When counter=DEPTH-1 is written: next state READY, RDY=1 on the following cycle.
  - Total: DEPTH cycles from reset release to RDY=1.
  - CE0/CE1/WE0/WE1/CLR are ignored; Q0/Q1 hold their values.
- READY:
  - Read: CE=1, WE=0 → Q shows mem[A] one cycle later (latency 1).
  - Write: CE=1, WE=1 → mem[A]<=D; that port's Q holds its previous value (no read-on-write).
  - Idle (CE=0) → Q holds its last value.
- Collisions in READY, same address, same cycle:
  - Both ports write: port 0 data stored; port 1 write dropped.
  - One port reads, other writes: the reader gets the new write data (write-through forwarding), not the old contents.
  - Both read: both get mem[A].
- CLR=1 in READY:
  - Next cycle state=CLEAR, RDY=0, counter=0.
  - Port access in the CLR cycle is still performed.
  - A full DEPTH-cycle clear follows.
- RSTN asserted mid-clear or mid-access: immediate return to CLEAR at counter 0; any write in flight at the reset edge is undefined and is overwritten by the clear.
- Address compare is full ABITS width; counter is ABITS bits and stops at DEPTH-1, with no wrap.

Optional Feature:
- BRAM_DP_OUTREG_EN defined:
  - Adds an output register stage on Q0/Q1 (reset to 0); read latency 2.
  - Hold, forwarding and collision rules apply unchanged, shifted by one cycle.
  - RDY timing unchanged.
- Undefined: latency 1 as above.

Decomposition:
- Package bram_dp_pkg:
  - state enum (CLEAR, READY);
  - read-latency constant (1 or 2, selected by the macro);
  - collision-priority constant (port 0).
- Sub-module bram_dp_core:
  - storage-only two-port array, ABITS x DBITS, no reset;
  - synchronous write and registered read per port, no forwarding.
- Top level holds:
  - clear FSM/counter;
  - port-0 muxing between clear writes and user writes;
  - collision detect/forwarding;
  - output hold/register.

Test Plan (ABITS=4, DBITS=8, INIT_VAL=8'hA5):
1. Release RSTN, then read all 16 addresses on both ports → RDY rises exactly 16 cycles after release; every read returns 8'hA5.
2. Write 8'h3C to addr 5 on port 0; next cycle read addr 5 on port 1 → Q1=8'h3C one cycle after the read (two with BRAM_DP_OUTREG_EN); Q0 unchanged after the write.
3. Same cycle: port 0 writes 8'h11 and port 1 writes 8'h22, both to addr 7; then read addr 7 → 8'h11.
4. Same cycle: port 1 writes 8'h77 to addr 2 while port 0 reads addr 2 (old value 8'hA5) → Q0=8'h77.
5. Pulse CLR after writes, issuing reads during the clear → RDY=0 for 16 cycles and Q holds during that time; afterwards all addresses read 8'hA5.
6. Assert RSTN at clear counter 9, release, and issue CE0 reads during the clear → accesses ignored; RDY rises 16 cycles after the second release; Q0=Q1=0 until the first post-ready read.
